// File: rtl/la_aosop_pipe.sv
// Pipelined AND-OR (sum-of-products) datapath: N masked product terms of K inputs,
// W bits per lane, optional inversion, two-stage valid/ready pipeline and saturating hit counter.
module la_aosop_pipe #(
    parameter int W    = 8,
    parameter int N    = 3,
    parameter int K    = 2,
    parameter int CW   = 16,
    parameter     PROP = "DEFAULT"
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*K*W-1:0]   in_data,
    input  logic [N-1:0]       in_mask,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_z,
    input  logic               cnt_clr,
    output logic [CW-1:0]      hit_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [N*W-1:0] r_terms1;
    logic           r_inv1;
    logic           r_v1;
    logic [W-1:0]   r_z2;
    logic           r_v2;
    logic [CW-1:0]  r_cnt;

    logic [N*W-1:0] w_terms;
    logic [W-1:0]   w_or;
    logic [W-1:0]   w_z;
    logic           w_rdy1;
    logic           w_rdy2;
    logic           w_hit;

    // The property string selects no alternative implementation here.
    if (PROP == "") begin : g_prop_empty
    end

    // Each term starts from its mask bit so a disabled term reduces to zero.
    for (genvar gi = 0; gi < N; gi++) begin : g_term
        logic [W-1:0] w_prod;
        always_comb begin
            w_prod = {W{in_mask[gi]}};
            for (int k = 0; k < K; k++) begin
                w_prod = w_prod & in_data[((gi*K)+k)*W +: W];
            end
        end
        assign w_terms[gi*W +: W] = w_prod;
    end

    always_comb begin
        w_or = '0;
        for (int t = 0; t < N; t++) begin
            w_or = w_or | r_terms1[t*W +: W];
        end
    end

    assign w_z      = w_or ^ {W{r_inv1}};
    assign w_rdy2   = !r_v2 || out_ready;
    assign w_rdy1   = !r_v1 || w_rdy2;
    assign w_hit    = r_v2 && out_ready && (r_z2 != '0);

    assign in_ready  = w_rdy1;
    assign out_valid = r_v2;
    assign out_z     = r_z2;
    assign hit_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_terms1 <= '0;
            r_inv1   <= 1'b0;
            r_v1     <= 1'b0;
            r_z2     <= '0;
            r_v2     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // Stage 1 refills (or empties) whenever stage 2 can take its contents.
            if (w_rdy1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_terms1 <= w_terms;
                    r_inv1   <= in_inv;
                end
            end
            if (w_rdy2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_z2 <= w_z;
                end
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_hit && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/la_aosop_pipe.md
Name: la_aosop_pipe

Overview:
Parametrised, pipelined AND-OR (sum-of-products) datapath: the next generation of the stdlib ao-family gates. It generalises a fixed 2-2-1 AND-OR gate to N terms of K inputs each, W bits wide per lane. It adds a per-transaction term mask, optional output inversion (AOI mode), a two-stage valid/ready pipeline with full backpressure, and a saturating hit counter. It sits in stdlib-based datapaths where wide bitwise SOP logic must be retimed and flow-controlled.

Parameters:
W, 8, lane width in bits (>=1)
N, 3, number of product terms (>=1)
K, 2, inputs per product term (>=1)
CW, 16, hit counter width (>=1)
PROP, "DEFAULT", implementation property string, passed through and functionally ignored

Ports:
clk  input  1  clock; all state updates on rising edge
nreset  input  1  synchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  input accepted when in_valid & in_ready
in_data  input  N*K*W  operand for term t, input k at bits [((t*K)+k)*W +: W]
in_mask  input  N  term enable; bit t=0 forces term t to zero
in_inv  input  1  1 = invert result (AOI mode)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts when out_valid & out_ready
out_z  output  W  result
cnt_clr  input  1  synchronous clear of hit_cnt
hit_cnt  output  CW  count of accepted outputs with out_z != 0, saturating

Behaviour:
- Reset (nreset=0 at an edge): v1, v2, out_valid=0, out_z=0, hit_cnt=0, and all stage data registers 0. in_ready is 1 during and after reset, since it derives from the cleared valids. Reset asserted mid-stream drops all in-flight data with no output.
- Function per bit i: term_t[i] = in_mask[t] & AND over k of op(t,k)[i]; or_i = OR over t of term_t[i]; z[i] = or_i ^ in_inv.
- Stage 1 (on accept): register N*W term vector and inv flag; v1<=1.
- Stage 2: register z = OR(terms) ^ inv into out_z; v2 (=out_valid) <=1.
- Flow control: rdy2 = !v2 | out_ready; rdy1 = !v1 | rdy2; in_ready = rdy1. The combinational ready path is permitted. A stage loads only when its ready is 1; otherwise it holds its data and valid.
- Stage 1 clears v1 when it hands off to stage 2 and no new input is accepted. Stage 2 clears v2 when out_ready=1 and v1=0.
- Latency: 2 cycles from accept edge to out_valid. Throughput is 1 per cycle when out_ready is held high.
- Stability: while out_valid & !out_ready, out_z holds constant. No data is lost or duplicated under any stall pattern. Capacity is 2 transactions.
- Boundary: in_mask all-zero gives z=0, or all-ones when in_inv=1. For N=1, K=1, the block acts as a registered buffer/inverter.
- hit_cnt: increments by 1 on each cycle with out_valid & out_ready & (out_z != 0). It saturates at 2^CW-1 and does not wrap. cnt_clr=1 forces 0 and wins over a simultaneous increment.
- in_valid deasserted: pipeline drains normally. Inputs are sampled only on an accept edge.

Test Plan:
- Basic AO (W=8,N=3,K=2,mask=3'b111,inv=0): a0=F0,a1=3C,b0=0F,b1=FF,c0=81,c1=01 -> out_z=0x3F exactly 2 cycles after accept.
- Mask/AOI: same operands, mask=3'b010, inv=1 -> out_z=0xF0. Mask=0, inv=0 -> out_z=0x00, and hit_cnt unchanged.
- Backpressure: stream 5 transactions with out_ready=0 for cycles 2-6. Required: in_ready drops after 2 accepts, out_z is stable while stalled, and all 5 results emerge in order with none lost.
- Full throughput: out_ready=1, in_valid=1 for 10 cycles -> 10 results on consecutive cycles, in_ready never drops.
- Counter: CW=2, issue 5 nonzero results -> hit_cnt saturates at 3. Assert cnt_clr together with a nonzero accept -> hit_cnt=0.
- Reset mid-operation: nreset=0 for one edge with 2 transactions in flight -> out_valid=0, out_z=0, hit_cnt=0 next cycle, no stale output afterward.
